// File: rtl/kh_disp_pkg.sv
// Shared display definitions: segment bit positions, hex glyphs, frame snapshot record.
package kh_disp_pkg;

    localparam int unsigned NUM_TUBES = 8;

    // Segment bus layout {a,b,c,d,e,f,g,dp} on bits [7:0]
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Glyphs as {a,b,c,d,e,f,g}
    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    localparam logic [15:0][6:0] HEX_GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    // Per-frame copy of the display request, frozen at frame start
    typedef struct packed {
        logic [4*NUM_TUBES-1:0] hex;
        logic [NUM_TUBES-1:0]   en;
        logic [NUM_TUBES-1:0]   blink;
        logic [NUM_TUBES-1:0]   dp;
    } frame_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex code to {a..g} segment pattern.
module seg_hex_decoder
    import kh_disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Table lookup of the hex glyph
    always_comb begin
        o_seg = HEX_GLYPHS[i_code];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for two 4-tube seven-segment groups with blink,
// decimal-point and enable masks frozen once per frame.
module seg_scan_driver
    import kh_disp_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES       = 100_000,
    parameter int unsigned BLANK_CYCLES      = 1_000,
    parameter int unsigned BLINK_HALF_CYCLES = 25_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_on,
    input  logic [31:0] hex_in,
    input  logic [7:0]  en_mask,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel,
    output logic        frame_tick
);

    localparam int unsigned SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

    logic [SLOT_W-1:0]    r_slot_cnt;
    logic [2:0]           r_idx;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink_ph;
    frame_t               r_shadow;
    logic [7:0]           r_digit1;
    logic [7:0]           r_digit2;
    logic [NUM_TUBES-1:0] r_tube_sel;
    logic                 r_frame_tick;

    logic       w_snap;
    logic       w_lit;
    logic [3:0] w_code;
    logic [6:0] w_glyph;
    logic [7:0] w_seg;

    assign w_snap = (r_idx == 3'd0) && (r_slot_cnt == '0);
    assign w_code = r_shadow.hex[{r_idx, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    // Tube is lit only past the anti-ghost window, with display on and tube enabled
    always_comb begin
        w_lit = (r_slot_cnt >= BLANK_END) && disp_on && r_shadow.en[r_idx];
        w_seg = SEG_BLANK;
        w_seg[SEG_A:SEG_G] = w_glyph;
        w_seg[SEG_DP]      = r_shadow.dp[r_idx];
        if (r_shadow.blink[r_idx] && r_blink_ph) begin
            w_seg = SEG_BLANK;
        end
    end

    // Free-running scan counters: slot cycle and tube index
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Blink phase generator, independent of the scan
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Frame snapshot of the display request at the start of tube 0's slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (w_snap) begin
            r_shadow <= '{hex: hex_in, en: en_mask, blink: blink_mask, dp: dp_mask};
        end
    end

    // Registered pin outputs; the idle group bus is held at zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_digit1     <= '0;
            r_digit2     <= '0;
            r_tube_sel   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
            r_tube_sel   <= w_lit ? (NUM_TUBES'(1) << r_idx) : '0;
            r_digit1     <= (w_lit && !r_idx[2]) ? w_seg : SEG_BLANK;
            r_digit2     <= (w_lit &&  r_idx[2]) ? w_seg : SEG_BLANK;
        end
    end

    assign digit1     = r_digit1;
    assign digit2     = r_digit2;
    assign tube_sel   = r_tube_sel;
    assign frame_tick = r_frame_tick;

endmodule
